// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline hazard controller for the fetch/decode and decode/execute-memory
// buffers and the PC register. It handles taken branches, load-use stalls
// and two-word PC push/pop transfers.
// Optional build macro: HAZARD_PERF_COUNTERS_EN adds saturating stall and
// flush counters. Without it, both counter outputs are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal flow; branch, push/pop and load-use are evaluated
// ST_XFER  | second (high) 16-bit word of a PC push/pop transfer
// ST_DRAIN | after a pop: load the popped PC and flush the front end

module hazard_control_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_dec_rs1,
  input  logic        i_dec_rs1_used,
  input  logic [2:0]  i_dec_rs2,
  input  logic        i_dec_rs2_used,
  input  logic [2:0]  i_ex_rd,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_write_back,
  input  logic        i_ex_push_pc,
  input  logic        i_ex_pop_pc,
  input  logic        i_branch_taken,
  output logic        o_pc_enable,
  output logic        o_fd_enable,
  output logic        o_fd_flush,
  output logic        o_de_enable,
  output logic        o_de_flush,
  output logic        o_pc_half,
  output logic        o_busy,
  output logic [15:0] o_stall_count,
  output logic [15:0] o_flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   pop_q, pop_d;
  logic   load_use;

  assign load_use = i_ex_mem_read & i_ex_write_back &
                    ((i_dec_rs1_used & (i_dec_rs1 == i_ex_rd)) |
                     (i_dec_rs2_used & (i_dec_rs2 == i_ex_rd)));

  // Next-state and control outputs. Reset forces the safe values.
  always_comb begin
    state_d     = state_q;
    pop_d       = pop_q;
    o_pc_enable = 1'b1;
    o_fd_enable = 1'b1;
    o_fd_flush  = 1'b0;
    o_de_enable = 1'b1;
    o_de_flush  = 1'b0;
    o_pc_half   = 1'b0;
    o_busy      = (state_q != ST_RUN);

    case (state_q)
      ST_RUN: begin
        if (i_branch_taken) begin
          o_fd_flush = 1'b1;
          o_de_flush = 1'b1;
        end else if (i_ex_push_pc || i_ex_pop_pc) begin
          // Hold the CALL/RET in EX/M while the first word moves.
          o_pc_enable = 1'b0;
          o_fd_enable = 1'b0;
          o_de_enable = 1'b0;
          pop_d       = i_ex_pop_pc;
          state_d     = ST_XFER;
        end else if (load_use) begin
          o_pc_enable = 1'b0;
          o_fd_enable = 1'b0;
          o_de_flush  = 1'b1;
        end
      end
      ST_XFER: begin
        o_pc_half   = 1'b1;
        o_pc_enable = 1'b0;
        o_fd_enable = 1'b0;
        o_de_flush  = 1'b1;
        state_d     = pop_q ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        o_fd_flush = 1'b1;
        o_de_flush = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (i_reset) begin
      o_pc_enable = 1'b0;
      o_fd_enable = 1'b0;
      o_de_enable = 1'b0;
      o_fd_flush  = 1'b1;
      o_de_flush  = 1'b1;
      o_pc_half   = 1'b0;
      o_busy      = 1'b0;
    end
  end

  // State register, together with the latched push-vs-pop flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments. The outputs are already forced while in reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!o_pc_enable && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if ((o_fd_flush || o_de_flush) && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
  assign o_flush_count = flush_cnt_q;
`else
  assign o_stall_count = 16'h0000;
  assign o_flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed testbench for hazard_control_unit.
// The bench changes inputs just after a falling edge. It checks the
// combinational outputs 1 ns later, well away from the rising edge.
module tb_hazard_control_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [2:0]  i_dec_rs1, i_dec_rs2, i_ex_rd;
  logic        i_dec_rs1_used, i_dec_rs2_used;
  logic        i_ex_mem_read, i_ex_write_back;
  logic        i_ex_push_pc, i_ex_pop_pc, i_branch_taken;
  logic        o_pc_enable, o_fd_enable, o_fd_flush;
  logic        o_de_enable, o_de_flush, o_pc_half, o_busy;
  logic [15:0] o_stall_count, o_flush_count;

  int n_cmp = 0;
  int n_err = 0;

  hazard_control_unit dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_dec_rs1(i_dec_rs1), .i_dec_rs1_used(i_dec_rs1_used),
    .i_dec_rs2(i_dec_rs2), .i_dec_rs2_used(i_dec_rs2_used),
    .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read),
    .i_ex_write_back(i_ex_write_back), .i_ex_push_pc(i_ex_push_pc),
    .i_ex_pop_pc(i_ex_pop_pc), .i_branch_taken(i_branch_taken),
    .o_pc_enable(o_pc_enable), .o_fd_enable(o_fd_enable),
    .o_fd_flush(o_fd_flush), .o_de_enable(o_de_enable),
    .o_de_flush(o_de_flush), .o_pc_half(o_pc_half), .o_busy(o_busy),
    .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_dec_rs1 = 3'd0; i_dec_rs1_used = 1'b0;
    i_dec_rs2 = 3'd0; i_dec_rs2_used = 1'b0;
    i_ex_rd = 3'd0; i_ex_mem_read = 1'b0; i_ex_write_back = 1'b0;
    i_ex_push_pc = 1'b0; i_ex_pop_pc = 1'b0; i_branch_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge i_clk);
    #1;
  endtask

  task automatic set_load_use(input logic [2:0] rd, input logic [2:0] rs1, input logic u1,
                              input logic [2:0] rs2, input logic u2);
    i_ex_mem_read = 1'b1; i_ex_write_back = 1'b1; i_ex_rd = rd;
    i_dec_rs1 = rs1; i_dec_rs1_used = u1;
    i_dec_rs2 = rs2; i_dec_rs2_used = u2;
  endtask

  // Checks the fixed output values expected while reset is asserted.
  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_pc_en"},   {15'd0, o_pc_enable}, 16'd0);
    chk({pfx, "_fd_en"},   {15'd0, o_fd_enable}, 16'd0);
    chk({pfx, "_de_en"},   {15'd0, o_de_enable}, 16'd0);
    chk({pfx, "_fd_fl"},   {15'd0, o_fd_flush},  16'd1);
    chk({pfx, "_de_fl"},   {15'd0, o_de_flush},  16'd1);
    chk({pfx, "_half"},    {15'd0, o_pc_half},   16'd0);
    chk({pfx, "_busy"},    {15'd0, o_busy},      16'd0);
    chk({pfx, "_stall"},   o_stall_count,        16'd0);
    chk({pfx, "_flush"},   o_flush_count,        16'd0);
  endtask

  // Checks the RUN-state defaults: all enables high, no flushes, not busy.
  task automatic chk_run_defaults(input string pfx);
    chk({pfx, "_pc_en"}, {15'd0, o_pc_enable}, 16'd1);
    chk({pfx, "_fd_en"}, {15'd0, o_fd_enable}, 16'd1);
    chk({pfx, "_de_en"}, {15'd0, o_de_enable}, 16'd1);
    chk({pfx, "_fd_fl"}, {15'd0, o_fd_flush},  16'd0);
    chk({pfx, "_de_fl"}, {15'd0, o_de_flush},  16'd0);
    chk({pfx, "_half"},  {15'd0, o_pc_half},   16'd0);
    chk({pfx, "_busy"},  {15'd0, o_busy},      16'd0);
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    #1;
    chk_reset_vals("rst0");
    next_cycle();
    i_reset = 1'b0;
    next_cycle();
    chk_run_defaults("run0");

    // Load-use hazard on rs2.
    set_load_use(3'd3, 3'd0, 1'b0, 3'd3, 1'b1);
    #1;
    chk("lu2_pc_en", {15'd0, o_pc_enable}, 16'd0);
    chk("lu2_fd_en", {15'd0, o_fd_enable}, 16'd0);
    chk("lu2_de_fl", {15'd0, o_de_flush},  16'd1);
    chk("lu2_busy",  {15'd0, o_busy},      16'd0);
    next_cycle();
    // The same pattern with rs2_used low does not stall.
    i_dec_rs2_used = 1'b0;
    #1;
    chk("lu2n_pc_en", {15'd0, o_pc_enable}, 16'd1);
    chk("lu2n_fd_en", {15'd0, o_fd_enable}, 16'd1);
    chk("lu2n_de_fl", {15'd0, o_de_flush},  16'd0);
    next_cycle();
    // Load-use hazard on rs1.
    set_load_use(3'd5, 3'd5, 1'b1, 3'd2, 1'b1);
    #1;
    chk("lu1_pc_en", {15'd0, o_pc_enable}, 16'd0);
    next_cycle();
    // A destination that matches neither source does not stall.
    set_load_use(3'd6, 3'd5, 1'b1, 3'd2, 1'b1);
    #1;
    chk("lurd_pc_en", {15'd0, o_pc_enable}, 16'd1);
    next_cycle();
    // A register that is written back but not loaded does not stall.
    set_load_use(3'd5, 3'd5, 1'b1, 3'd2, 1'b1);
    i_ex_mem_read = 1'b0;
    #1;
    chk("lunl_pc_en", {15'd0, o_pc_enable}, 16'd1);
    next_cycle();

    // A taken branch takes priority over a load-use hazard.
    set_load_use(3'd3, 3'd0, 1'b0, 3'd3, 1'b1);
    i_branch_taken = 1'b1;
    #1;
    chk("br_fd_fl", {15'd0, o_fd_flush},  16'd1);
    chk("br_de_fl", {15'd0, o_de_flush},  16'd1);
    chk("br_pc_en", {15'd0, o_pc_enable}, 16'd1);
    chk("br_fd_en", {15'd0, o_fd_enable}, 16'd1);
    next_cycle();
    // A taken branch also takes priority over a push; the FSM stays in RUN.
    idle_inputs();
    i_branch_taken = 1'b1; i_ex_push_pc = 1'b1;
    next_cycle();
    idle_inputs();
    #1;
    chk("brpush_busy", {15'd0, o_busy}, 16'd0);
    next_cycle();

    // Pop sequence: pc_half goes 0,1,0 and busy goes 0,1,1,0.
    i_ex_pop_pc = 1'b1;
    #1;
    chk("pop0_half",  {15'd0, o_pc_half},   16'd0);
    chk("pop0_busy",  {15'd0, o_busy},      16'd0);
    chk("pop0_pc_en", {15'd0, o_pc_enable}, 16'd0);
    chk("pop0_fd_en", {15'd0, o_fd_enable}, 16'd0);
    chk("pop0_de_en", {15'd0, o_de_enable}, 16'd0);
    next_cycle();
    i_ex_pop_pc = 1'b0;
    #1;
    chk("pop1_half",  {15'd0, o_pc_half},   16'd1);
    chk("pop1_busy",  {15'd0, o_busy},      16'd1);
    chk("pop1_pc_en", {15'd0, o_pc_enable}, 16'd0);
    chk("pop1_fd_en", {15'd0, o_fd_enable}, 16'd0);
    chk("pop1_de_fl", {15'd0, o_de_flush},  16'd1);
    next_cycle();
    chk("pop2_half",  {15'd0, o_pc_half},   16'd0);
    chk("pop2_busy",  {15'd0, o_busy},      16'd1);
    chk("pop2_pc_en", {15'd0, o_pc_enable}, 16'd1);
    chk("pop2_fd_fl", {15'd0, o_fd_flush},  16'd1);
    chk("pop2_de_fl", {15'd0, o_de_flush},  16'd1);
    next_cycle();
    chk_run_defaults("pop3");

    // Push with a branch during XFER: the branch is ignored and the FSM
    // returns to RUN after two cycles.
    i_ex_push_pc = 1'b1;
    #1;
    chk("push0_half", {15'd0, o_pc_half}, 16'd0);
    next_cycle();
    i_ex_push_pc = 1'b0; i_branch_taken = 1'b1;
    #1;
    chk("push1_busy",  {15'd0, o_busy},      16'd1);
    chk("push1_half",  {15'd0, o_pc_half},   16'd1);
    chk("push1_fd_fl", {15'd0, o_fd_flush},  16'd0);
    chk("push1_pc_en", {15'd0, o_pc_enable}, 16'd0);
    next_cycle();
    i_branch_taken = 1'b0;
    #1;
    chk_run_defaults("push2");

    // Reset pulse in the middle of XFER.
    i_ex_pop_pc = 1'b1;
    next_cycle();
    i_ex_pop_pc = 1'b0;
    #1;
    chk("rx_busy_pre", {15'd0, o_busy}, 16'd1);
    i_reset = 1'b1;
    #1;
    chk_reset_vals("rx");
    next_cycle();
    i_reset = 1'b0;
    #1;
    chk_run_defaults("rx_rel");
    next_cycle();
    chk_run_defaults("rx_rel2");

    // Performance counters.
    i_reset = 1'b1;
    next_cycle();
    i_reset = 1'b0;
    i_branch_taken = 1'b1;
    repeat (5) next_cycle();
    i_branch_taken = 1'b0;
    #1;
`ifdef HAZARD_PERF_COUNTERS_EN
    chk("cnt_flush5", o_flush_count, 16'd5);
    chk("cnt_stall0", o_stall_count, 16'd0);
`else
    chk("cnt_flush_off", o_flush_count, 16'd0);
`endif
    set_load_use(3'd3, 3'd0, 1'b0, 3'd3, 1'b1);
    repeat (70000) @(posedge i_clk);
    next_cycle();
`ifdef HAZARD_PERF_COUNTERS_EN
    chk("cnt_stall_sat", o_stall_count, 16'hFFFF);
    chk("cnt_flush_sat", o_flush_count, 16'hFFFF);
`else
    chk("cnt_stall_off", o_stall_count, 16'h0000);
    chk("cnt_flush_off2", o_flush_count, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
